// File: rtl/fp8_pkg.sv
// Shared FP8 definitions: field positions, op codes, flag bit indices and a
// helper that turns an FP8 magnitude into an unsigned fixed-point integer.
package fp8_pkg;

   localparam int SIGN_B  = 7;
   localparam int EXP_MSB = 6;
   localparam int EXP_LSB = 4;
   localparam int MAN_W   = 4;
   localparam int BIAS    = 3;
   localparam int EXP_MAX = 7;

   // Fraction bits of the fixed-point form; the smallest normal exponent maps to bit 0.
   localparam int FIX_LSB = 6;
   // Extra fraction bits kept by the divider before truncation.
   localparam int DIV_EXT = 8;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_DIV = 3'b011;

   localparam int FLG_OVF  = 0;
   localparam int FLG_UNF  = 1;
   localparam int FLG_ZERO = 2;
   localparam int FLG_INV  = 3;

   // Zero exponent encodes zero; otherwise value = 1.m * 2^(e-BIAS).
   function automatic logic [10:0] to_fix(input logic [6:0] x);
      logic [2:0] e;
      e = x[EXP_MSB:EXP_LSB];
      if (e == 3'd0) return 11'd0;
      return 11'({1'b1, x[MAN_W-1:0]}) << (e - 3'd1);
   endfunction

endpackage

// File: rtl/fp8_alu.sv
// Combinational FP8 add/sub/mul/div. Results truncate toward zero, saturate
// on overflow or divide-by-zero, and flush to zero on underflow.
module fp8_alu
   import fp8_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [2:0] op,
   output logic [7:0] result,
   output logic [3:0] flags
);

   logic [10:0]        fa, fb;
   logic               sa, sb;
   logic signed [12:0] va, vb, sum;
   logic [23:0]        mag;
   logic               sign, nz, div0, inv;
   int                 lsb, msb, ex;

   assign fa = to_fix(a[6:0]);
   assign fb = to_fix(b[6:0]);
   assign sa = a[SIGN_B];
   assign sb = b[SIGN_B] ^ (op == OP_SUB);

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      va     = sa ? -$signed({2'b00, fa}) : $signed({2'b00, fa});
      vb     = sb ? -$signed({2'b00, fb}) : $signed({2'b00, fb});
      sum    = va + vb;
      mag    = '0;
      lsb    = 0;
      nz     = 1'b0;
      div0   = 1'b0;
      inv    = 1'b0;
      sign   = sa ^ sb;
      result = '0;
      flags  = '0;

      case (op)
         OP_ADD, OP_SUB: begin
            mag  = 24'(sum < 0 ? -sum : sum);
            sign = sum[12];
            lsb  = FIX_LSB;
            nz   = (sum != 0);
         end
         OP_MUL: begin
            mag = 24'(fa) * 24'(fb);
            lsb = 2 * FIX_LSB;
            nz  = (mag != 0);
         end
         OP_DIV: begin
            div0 = (fb == 11'd0);
            mag  = div0 ? '0 : (24'(fa) << DIV_EXT) / 24'(fb);
            lsb  = DIV_EXT;
            nz   = (fa != 11'd0);
         end
         default: inv = 1'b1;
      endcase

      msb = 0;
      for (int i = 0; i < 24; i++) begin
         if (mag[i]) msb = i;
      end
      ex = msb - lsb + BIAS;

      if (inv) begin
         flags[FLG_INV] = 1'b1;
      end else if (div0 || (nz && ex > EXP_MAX)) begin
         result         = {sign, 7'h7F};
         flags[FLG_OVF] = 1'b1;
      end else if (nz && ex < 1) begin
         flags[FLG_UNF] = 1'b1;
      end else if (nz) begin
         result = {sign, 3'(ex), 4'(mag >> (msb - MAN_W))};
      end
      flags[FLG_ZERO] = (result == 8'd0);
   end

endmodule

// File: rtl/fp8_res_fifo.sv
// Synchronous result FIFO with occupancy counter; simultaneous write and read
// are allowed when full, and flush empties it in one edge.
module fp8_res_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_en,
   output logic [W-1:0] rd_data,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr];

   // NOTE: storage is reset so the head reads zero after reset; sequential
   // state uses non-blocking assignments throughout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
      end
   end

endmodule

// File: rtl/fp8_alu_stream.sv
// Valid/ready front-end for fp8_alu: one command register stage feeding the
// ALU, a result FIFO on the output, sticky flags and an operation counter.
module fp8_alu_stream
   import fp8_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int TAG_W      = 4,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_a,
   input  logic [7:0]       in_b,
   input  logic [2:0]       in_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_result,
   output logic [3:0]       out_flags,
   output logic [TAG_W-1:0] out_tag,
   output logic [3:0]       sticky,
   input  logic             clr_sticky,
   output logic [CNT_W-1:0] ops_count
);

   localparam int ENT_W = 8 + 4 + TAG_W;

   logic             s1_valid, rdy_q;
   logic [7:0]       s1_a, s1_b;
   logic [2:0]       s1_op;
   logic [TAG_W-1:0] s1_tag;
   logic [7:0]       alu_result;
   logic [3:0]       alu_flags;
   logic             fifo_full, fifo_empty, pop, adv, wr, accept;
   logic [ENT_W-1:0] head;

   assign out_valid = !fifo_empty;
   assign pop       = out_valid & out_ready;
   assign adv       = s1_valid & (!fifo_full | pop);
   // A flush discards the S1 write, so it must not reach sticky or ops_count either.
   assign wr        = adv & !flush;
   assign in_ready  = rdy_q & !flush & (!s1_valid | adv);
   assign accept    = in_valid & in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_q    <= 1'b0;
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_op    <= '0;
         s1_tag   <= '0;
      end else begin
         rdy_q <= 1'b1;
         if (flush) begin
            s1_valid <= 1'b0;
         end else if (accept) begin
            s1_valid <= 1'b1;
            s1_a     <= in_a;
            s1_b     <= in_b;
            s1_op    <= in_op;
            s1_tag   <= in_tag;
         end else if (adv) begin
            s1_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky    <= '0;
         ops_count <= '0;
      end else begin
         if (clr_sticky)  sticky <= '0;
         else if (wr)     sticky <= sticky | alu_flags;
         if (wr) ops_count <= ops_count + CNT_W'(1);
      end
   end

   fp8_alu u_alu (
      .a      (s1_a),
      .b      (s1_b),
      .op     (s1_op),
      .result (alu_result),
      .flags  (alu_flags)
   );

   fp8_res_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (ENT_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .wr_en   (wr),
      .wr_data ({alu_result, alu_flags, s1_tag}),
      .rd_en   (pop),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign out_result = head[ENT_W-1 -: 8];
   assign out_flags  = head[TAG_W+3 -: 4];
   assign out_tag    = head[TAG_W-1:0];

endmodule

// File: tb/tb_fp8_alu_stream.sv
// Self-checking bench for fp8_alu_stream: real-valued FP8 reference plus a
// queue-based model of the S1 register and result FIFO.
module tb_fp8_alu_stream;

   localparam int DEPTH = 4;
   localparam int TAG_W = 4;
   localparam int CNT_W = 16;

   typedef struct packed {
      logic [7:0]       res;
      logic [3:0]       flg;
      logic [TAG_W-1:0] tag;
   } ent_t;

   logic             clk = 1'b0;
   logic             rst_n, flush, in_valid, in_ready, out_valid, out_ready, clr_sticky;
   logic [7:0]       in_a, in_b, out_result;
   logic [2:0]       in_op;
   logic [TAG_W-1:0] in_tag, out_tag;
   logic [3:0]       out_flags, sticky;
   logic [CNT_W-1:0] ops_count;

   int n_assert = 0;
   int n_fail   = 0;
   int dut_acc  = 0;

   ent_t             fifo_m[$];
   ent_t             s1_m;
   bit               s1_full_m, rdy_m, accepted;
   logic [3:0]       sticky_m;
   logic [CNT_W-1:0] cnt_m;

   logic [7:0]       pop_res[$];
   logic [3:0]       pop_flg[$];
   logic [TAG_W-1:0] pop_tag[$];

   fp8_alu_stream #(
      .FIFO_DEPTH (DEPTH),
      .TAG_W      (TAG_W),
      .CNT_W      (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_op      (in_op),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_flags  (out_flags),
      .out_tag    (out_tag),
      .sticky     (sticky),
      .clr_sticky (clr_sticky),
      .ops_count  (ops_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", name, obs, exp);
      end
   endtask

   function automatic real fp_val(input logic [7:0] x);
      int  e;
      real m;
      e = int'(x[6:4]);
      if (e == 0) return 0.0;
      m = (1.0 + real'(x[3:0]) / 16.0) * (2.0 ** (e - 3));
      return x[7] ? -m : m;
   endfunction

   // Returns {result, flags}; flags = {invalid, zero, underflow, overflow}.
   function automatic logic [11:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op);
      real  va, vb, r, mag;
      int   e, man;
      logic neg;
      if (op > 3'd3) return {8'h00, 4'b1100};
      va = fp_val(a);
      vb = fp_val(b);
      case (op)
         3'd0:    r = va + vb;
         3'd1:    r = va - vb;
         3'd2:    r = va * vb;
         default: begin
            if (vb == 0.0) return {a[7] ^ b[7], 7'h7F, 4'b0001};
            r = va / vb;
         end
      endcase
      if (r == 0.0) return {8'h00, 4'b0100};
      neg = (r < 0.0);
      mag = neg ? -r : r;
      if (mag >= 32.0) return {neg, 7'h7F, 4'b0001};
      if (mag < 0.25)  return {8'h00, 4'b0110};
      e = 7;
      while (mag < 2.0 ** (e - 3)) e--;
      man = int'($floor((mag / (2.0 ** (e - 3)) - 1.0) * 16.0));
      return {neg, 3'(e), 4'(man), 4'b0000};
   endfunction

   task automatic model_reset();
      fifo_m.delete();
      s1_full_m = 1'b0;
      rdy_m     = 1'b0;
      sticky_m  = '0;
      cnt_m     = '0;
   endtask

   // One clock: called at a falling edge with inputs already driven.
   task automatic tick();
      bit   pop_m, adv_m, rdy_exp;
      ent_t e;
      #1;
      pop_m   = (fifo_m.size() > 0) && out_ready;
      adv_m   = s1_full_m && (fifo_m.size() < DEPTH || pop_m);
      rdy_exp = rdy_m && !flush && (!s1_full_m || adv_m);
      check("in_ready", 32'(in_ready), 32'(rdy_exp));
      check("out_valid", 32'(out_valid), 32'(fifo_m.size() > 0));
      if (fifo_m.size() > 0) begin
         check("out_result", 32'(out_result), 32'(fifo_m[0].res));
         check("out_flags", 32'(out_flags), 32'(fifo_m[0].flg));
         check("out_tag", 32'(out_tag), 32'(fifo_m[0].tag));
      end
      check("sticky", 32'(sticky), 32'(sticky_m));
      check("ops_count", 32'(ops_count), 32'(cnt_m));

      accepted = in_valid && rdy_exp;
      if (in_valid && in_ready) dut_acc++;
      if (pop_m) begin
         pop_res.push_back(out_result);
         pop_flg.push_back(out_flags);
         pop_tag.push_back(out_tag);
      end

      if (clr_sticky)               sticky_m = '0;
      else if (adv_m && !flush)     sticky_m = sticky_m | s1_m.flg;
      if (flush) begin
         fifo_m.delete();
         s1_full_m = 1'b0;
      end else begin
         if (pop_m) void'(fifo_m.pop_front());
         if (adv_m) begin
            fifo_m.push_back(s1_m);
            cnt_m++;
         end
         if (accepted) begin
            {e.res, e.flg} = ref_alu(in_a, in_b, in_op);
            e.tag     = in_tag;
            s1_m      = e;
            s1_full_m = 1'b1;
         end else if (adv_m) begin
            s1_full_m = 1'b0;
         end
      end
      rdy_m = 1'b1;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                       input logic [TAG_W-1:0] tag);
      int n = 0;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_op    = op;
      in_tag   = tag;
      accepted = 1'b0;
      while (!accepted && n < 40) begin
         tick();
         n++;
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      out_ready = 1'b1;
      while ((fifo_m.size() > 0 || s1_full_m) && n < 50) begin
         tick();
         n++;
      end
   endtask

   task automatic clear_pops();
      pop_res.delete();
      pop_flg.delete();
      pop_tag.delete();
   endtask

   initial begin
      logic [CNT_W-1:0] cnt0;

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
      in_a = '0; in_b = '0; in_op = '0; in_tag = '0;
      model_reset();
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_result", 32'(out_result), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Single add: 2.75 + 1.25 = 4.0
      out_ready = 1'b1;
      clear_pops();
      send(8'h46, 8'h34, 3'b000, 4'd5);
      drain();
      check("add_count", 32'(pop_res.size()), 32'd1);
      check("add_result", 32'(pop_res[0]), 32'h50);
      check("add_tag", 32'(pop_tag[0]), 32'd5);
      check("add_flags", 32'(pop_flg[0]), 32'd0);

      // Back-to-back mul then add
      clear_pops();
      cnt0 = ops_count;
      send(8'h44, 8'h40, 3'b010, 4'd1);
      send(8'h46, 8'h34, 3'b000, 4'd2);
      drain();
      check("b2b_first", 32'(pop_res[0]), 32'h54);
      check("b2b_second", 32'(pop_res[1]), 32'h50);
      check("b2b_ops", 32'(ops_count), 32'(cnt0 + 16'd2));

      // Backpressure: 6 commands into a depth-4 FIFO with the consumer stalled
      clear_pops();
      out_ready = 1'b0;
      dut_acc   = 0;
      for (int i = 0; i < 5; i++) send(8'(8'h40 + i), 8'h38, 3'b000, 4'(i));
      in_valid = 1'b1; in_a = 8'h52; in_b = 8'h31; in_op = 3'b010; in_tag = 4'd5;
      repeat (3) tick();
      check("bp_accepted", 32'(dut_acc), 32'd5);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      send(8'h52, 8'h31, 3'b010, 4'd5);
      drain();
      check("bp_pops", 32'(pop_tag.size()), 32'd6);
      for (int i = 0; i < 6; i++) check("bp_order", 32'(pop_tag[i]), 32'(i));

      // Overflow, invalid op, sticky clear
      clear_pops();
      send(8'h70, 8'h70, 3'b010, 4'd7);
      drain();
      check("ovf_flag", 32'(pop_flg[0][0]), 32'd1);
      check("ovf_sticky", 32'(sticky[0]), 32'd1);
      send(8'h46, 8'h34, 3'b111, 4'd8);
      drain();
      check("inv_flag", 32'(pop_flg[1][3]), 32'd1);
      clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;
      check("clr_sticky", 32'(sticky), 32'd0);

      // Flush with 3 queued and 1 in S1
      out_ready = 1'b0;
      cnt0 = cnt_m;
      for (int i = 0; i < 4; i++) send(8'h46, 8'(8'h34 + i), 3'b000, 4'(i));
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_out_valid", 32'(out_valid), 32'd0);
      check("flush_ops", 32'(ops_count), 32'(cnt0 + 16'd3));
      clear_pops();
      send(8'h44, 8'h40, 3'b011, 4'd9);
      drain();
      check("flush_pops", 32'(pop_tag.size()), 32'd1);
      check("flush_tag", 32'(pop_tag[0]), 32'd9);
      check("flush_div", 32'(pop_res[0]), 32'h34);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         in_valid   = ($urandom_range(0, 3) != 0);
         in_a       = 8'($urandom);
         in_b       = 8'($urandom);
         in_op      = 3'($urandom_range(0, 7) > 6 ? $urandom_range(4, 7) : $urandom_range(0, 3));
         in_tag     = 4'($urandom);
         out_ready  = ($urandom_range(0, 9) < 7);
         flush      = ($urandom_range(0, 59) == 0);
         clr_sticky = ($urandom_range(0, 29) == 0);
         tick();
      end
      in_valid = 1'b0; flush = 1'b0; clr_sticky = 1'b0;
      drain();

      // Asynchronous reset with entries queued
      out_ready = 1'b0;
      send(8'h70, 8'h70, 3'b010, 4'd1);
      send(8'h46, 8'h34, 3'b000, 4'd2);
      send(8'h44, 8'h40, 3'b010, 4'd3);
      tick();
      check("pre_rst_valid", 32'(out_valid), 32'd1);
      check("pre_rst_sticky", 32'(sticky[0]), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_sticky", 32'(sticky), 32'd0);
      check("mid_rst_ops", 32'(ops_count), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
